// File: rtl/tap_report_scheduler.sv
// Round-robin collector of checker verdicts into a one-deep record slot, numbering each
// accepted verdict TAP-style (1, 2, 3, ...) and closing the run with a "1..N" plan record.
module tap_report_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = 16,
  parameter int MSG_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_pass,
  input  logic [NUM_REQ*MSG_WIDTH-1:0] req_msg,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         finish_req,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1:0]                   out_kind,
  output logic [IDX_WIDTH-1:0]         out_index,
  output logic [MSG_WIDTH-1:0]         out_msg,
  output logic [IDX_WIDTH-1:0]         pass_count,
  output logic [IDX_WIDTH-1:0]         fail_count,
  output logic                         overflow,
  output logic                         done
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [IDX_WIDTH-1:0] IDX_MAX   = '1;
  localparam logic [1:0]           KIND_OK   = 2'd0;
  localparam logic [1:0]           KIND_NOK  = 2'd1;
  localparam logic [1:0]           KIND_PLAN = 2'd2;

  typedef enum logic [1:0] {S_RUN, S_PLAN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rr_q, rr_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [IDX_WIDTH-1:0] pass_q, pass_d;
  logic [IDX_WIDTH-1:0] fail_q, fail_d;
  logic                 overflow_q, overflow_d;
  logic                 done_q, done_d;
  logic                 out_valid_q, out_valid_d;
  logic [1:0]           out_kind_q, out_kind_d;
  logic [IDX_WIDTH-1:0] out_index_q, out_index_d;
  logic [MSG_WIDTH-1:0] out_msg_q, out_msg_d;

  logic                 slot_free;
  logic                 found;
  logic [PTR_W-1:0]     gnt_idx;
  int                   cand;

  // Arbiter: first valid requester at or after the round-robin pointer, wrapping around.
  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    slot_free = !out_valid_q || out_ready;
    found     = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    req_ready = '0;
    if (state_q == S_RUN && slot_free) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = int'(rr_q) + k;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        if (!found && req_valid[cand]) begin
          found   = 1'b1;
          gnt_idx = PTR_W'(cand);
        end
      end
    end
    if (found) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    idx_d       = idx_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    overflow_d  = overflow_q;
    done_d      = done_q;
    out_valid_d = out_valid_q && !out_ready;
    out_kind_d  = out_kind_q;
    out_index_d = out_index_q;
    out_msg_d   = out_msg_q;
    unique case (state_q)
      S_RUN: begin
        if (found) begin
          out_valid_d = 1'b1;
          out_kind_d  = req_pass[gnt_idx] ? KIND_OK : KIND_NOK;
          out_msg_d   = req_msg[int'(gnt_idx)*MSG_WIDTH +: MSG_WIDTH];
          // A saturated index keeps repeating and flags overflow instead of wrapping.
          if (idx_q == IDX_MAX) begin
            overflow_d  = 1'b1;
            out_index_d = IDX_MAX;
          end else begin
            idx_d       = idx_q + 1'b1;
            out_index_d = idx_q + 1'b1;
          end
          if (req_pass[gnt_idx]) begin
            if (pass_q != IDX_MAX) pass_d = pass_q + 1'b1;
          end else begin
            if (fail_q != IDX_MAX) fail_d = fail_q + 1'b1;
          end
          rr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
        if (finish_req) state_d = S_PLAN;
      end
      S_PLAN: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_kind_d  = KIND_PLAN;
          out_index_d = idx_q;
          out_msg_d   = '0;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        // Only the plan record can occupy the slot here, so any handshake is its acceptance.
        if (out_valid_q && out_ready) done_d = 1'b1;
      end
      default: state_d = S_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_RUN;
      rr_q        <= '0;
      idx_q       <= '0;
      pass_q      <= '0;
      fail_q      <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_kind_q  <= '0;
      out_index_q <= '0;
      out_msg_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_kind_q  <= out_kind_d;
      out_index_q <= out_index_d;
      out_msg_q   <= out_msg_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_kind   = out_kind_q;
  assign out_index  = out_index_q;
  assign out_msg    = out_msg_q;
  assign pass_count = pass_q;
  assign fail_count = fail_q;
  assign overflow   = overflow_q;
  assign done       = done_q;

endmodule

// File: tb/tb_tap_report_scheduler.sv
// Randomised scoreboard bench for tap_report_scheduler, plus a directed saturation run on a
// narrow-index instance.
module tb_tap_report_scheduler;

  localparam int N    = 4;
  localparam int IW   = 16;
  localparam int MW   = 8;
  localparam int IMAX = (1 << IW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n = 1'b0;
  logic [N-1:0]      req_valid = '0, req_pass = '0, req_ready;
  logic [N*MW-1:0]   req_msg = '0;
  logic              finish_req = 1'b0, out_valid, out_ready = 1'b0;
  logic [1:0]        out_kind;
  logic [IW-1:0]     out_index, pass_count, fail_count;
  logic [MW-1:0]     out_msg;
  logic              overflow, done;

  tap_report_scheduler #(.NUM_REQ(N), .IDX_WIDTH(IW), .MSG_WIDTH(MW)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_pass(req_pass),
    .req_msg(req_msg), .req_ready(req_ready), .finish_req(finish_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_index(out_index), .out_msg(out_msg), .pass_count(pass_count),
    .fail_count(fail_count), .overflow(overflow), .done(done)
  );

  // Narrow instance: index saturates at 3.
  logic            s_reset_n = 1'b0;
  logic [N-1:0]    s_req_valid = '0, s_req_pass = '0, s_req_ready;
  logic [N*MW-1:0] s_req_msg = '0;
  logic            s_finish_req = 1'b0, s_out_valid, s_out_ready = 1'b0;
  logic [1:0]      s_out_kind, s_out_index, s_pass_count, s_fail_count;
  logic [MW-1:0]   s_out_msg;
  logic            s_overflow, s_done;

  tap_report_scheduler #(.NUM_REQ(N), .IDX_WIDTH(2), .MSG_WIDTH(MW)) dut_sat (
    .clk(clk), .reset_n(s_reset_n), .req_valid(s_req_valid), .req_pass(s_req_pass),
    .req_msg(s_req_msg), .req_ready(s_req_ready), .finish_req(s_finish_req),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_kind(s_out_kind),
    .out_index(s_out_index), .out_msg(s_out_msg), .pass_count(s_pass_count),
    .fail_count(s_fail_count), .overflow(s_overflow), .done(s_done)
  );

  typedef struct {int kind; int index; int msg;} rec_t;
  rec_t sb[$];

  int n_checks = 0;
  int n_fails  = 0;
  bit in_reset = 1'b1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the run should look like, tracked as plain integers.
  int m_rr, m_idx, m_pass, m_fail, m_phase;  // phase 0 collecting, 1 closing, 2 closed
  bit m_valid, m_done, m_ovf;

  task automatic model_clear();
    m_rr = 0; m_idx = 0; m_pass = 0; m_fail = 0; m_phase = 0;
    m_valid = 0; m_done = 0; m_ovf = 0;
    sb.delete();
  endtask

  task automatic model_step();
    logic [N-1:0] exp_rdy;
    int  g;
    bit  sf, load;
    exp_rdy = '0;
    g       = -1;
    sf      = !m_valid || out_ready;
    if (m_phase == 0 && sf)
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    check("pass_count", pass_count, m_pass);
    check("fail_count", fail_count, m_fail);
    check("overflow", overflow, m_ovf);
    check("done", done, m_done);

    load = 0;
    if (m_phase == 0) begin
      if (g >= 0) begin
        load = 1;
        if (m_idx == IMAX) m_ovf = 1; else m_idx++;
        sb.push_back('{kind: req_pass[g] ? 0 : 1, index: m_idx, msg: int'(req_msg[g*MW +: MW])});
        if (req_pass[g]) begin if (m_pass < IMAX) m_pass++; end
        else begin if (m_fail < IMAX) m_fail++; end
        m_rr = (g + 1) % N;
      end
      if (finish_req) m_phase = 1;
    end else if (m_phase == 1) begin
      if (sf) begin
        load = 1;
        sb.push_back('{kind: 2, index: m_idx, msg: 0});
        m_phase = 2;
      end
    end else if (m_valid && out_ready) begin
      m_done = 1;
    end
    m_valid = load || (m_valid && !out_ready);
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks the hold rule.
  initial begin
    bit   hold;
    rec_t h, e;
    hold = 0;
    h = '{kind: 0, index: 0, msg: 0};
    forever begin
      @(negedge clk);
      #2;
      if (in_reset) begin
        hold = 0;
        continue;
      end
      if (hold) begin
        check("hold_kind", out_kind, h.kind);
        check("hold_index", out_index, h.index);
        check("hold_msg", out_msg, h.msg);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_record: got kind %0d index %0d, expected none", out_kind, out_index);
        end else begin
          e = sb.pop_front();
          check("rec_kind", out_kind, e.kind);
          check("rec_index", out_index, e.index);
          check("rec_msg", out_msg, e.msg);
        end
      end
      hold = out_valid && !out_ready;
      if (hold) h = '{kind: int'(out_kind), index: int'(out_index), msg: int'(out_msg)};
    end
  end

  task automatic do_reset();
    @(negedge clk);
    in_reset = 1'b1;
    reset_n = 1'b0;
    req_valid = '0; finish_req = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    model_clear();
    reset_n = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_kind", out_kind, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_msg", out_msg, 0);
    check("rst_pass", pass_count, 0);
    check("rst_fail", fail_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_done", done, 0);
    in_reset = 1'b0;
  endtask

  task automatic drive(input int mode, input int c);
    req_pass = N'($urandom);
    req_msg  = (N*MW)'($urandom);
    case (mode)
      0:       begin req_valid = '1;          out_ready = 1'b1; end
      2:       begin req_valid = N'($urandom); out_ready = (c % 12) >= 6; end
      3:       begin req_valid = '0;          out_ready = $urandom_range(0, 3) != 0; end
      default: begin req_valid = N'($urandom); out_ready = $urandom_range(0, 3) != 0; end
    endcase
  endtask

  // mode 0: all requesters busy, sink always ready; 1: random; 2: long sink stalls;
  // 3: no verdicts at all; 4: random, aborted by the next reset with records in flight.
  task automatic run_episode(input int mode, input int len);
    do_reset();
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      drive(mode, c);
      finish_req = (mode != 4) && (c == len - 1);
      #1 model_step();
    end
    if (mode == 4) return;
    for (int c = 0; c < 300 && !m_done; c++) begin
      @(negedge clk);
      drive(mode == 0 ? 1 : mode, c);
      finish_req = $urandom_range(0, 1) == 1;
      #1 model_step();
    end
    @(negedge clk);
    req_valid = '0; finish_req = 1'b0; out_ready = 1'b1;
    #3;
    check("done_reached", done, 1);
    check("req_ready_idle", req_ready, 0);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int exp_idx[4];
    exp_idx = '{1, 2, 3, 3};

    run_episode(0, 10);
    run_episode(1, 120);
    run_episode(2, 80);
    run_episode(4, 40);
    run_episode(3, 5);
    run_episode(1, 60);
    run_episode(2, 30);
    run_episode(0, 3);

    // Saturation on the narrow instance, then a reset with a record pending.
    @(negedge clk);
    s_reset_n = 1'b0;
    repeat (2) @(negedge clk);
    s_reset_n   = 1'b1;
    s_out_ready = 1'b1;
    s_req_pass  = '1;
    s_req_valid = 4'b0001;
    s_req_msg   = (N*MW)'(8'h20);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 3) s_req_valid = '0;
      s_req_msg = (N*MW)'(8'h21 + k);
      #1;
      check("sat_valid", s_out_valid, 1);
      check("sat_index", s_out_index, exp_idx[k]);
      check("sat_msg", s_out_msg, 8'h20 + k);
    end
    check("sat_overflow", s_overflow, 1);
    check("sat_pass", s_pass_count, 3);
    check("sat_fail", s_fail_count, 0);
    @(negedge clk);
    s_out_ready = 1'b0;
    s_req_valid = 4'b0100;
    @(negedge clk);
    #1 check("sat_pending", s_out_valid, 1);
    @(negedge clk);
    s_reset_n   = 1'b0;
    s_req_valid = '0;
    @(negedge clk);
    s_reset_n = 1'b1;
    #1;
    check("sat_rst_valid", s_out_valid, 0);
    check("sat_rst_overflow", s_overflow, 0);
    check("sat_rst_pass", s_pass_count, 0);
    check("sat_rst_index", s_out_index, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "timeout");
  end

endmodule
